// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin arbiter sharing one AXI-Stream master link among N requesters
// Ports: axis_aclk / axis_aresetn   clock and asynchronous active-low reset
//        s_axis_tvalid/tdata/tlast  per-requester inputs, requester i in bit i / slice [i*DW +: DW]
//        s_axis_tready              per-requester ready, only the owner's bit can be high
//        m_axis_*                   shared master port, routed combinationally from the owner
//        grant_valid / grant_id     current owner of the link
//        pkt_cnt                    running count of completed packets (wraps)
module axis_rr_arbiter #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int IW = $clog2(N)
) (
  input  logic            axis_aclk,
  input  logic            axis_aresetn,
  input  logic [N-1:0]    s_axis_tvalid,
  input  logic [N*DW-1:0] s_axis_tdata,
  input  logic [N-1:0]    s_axis_tlast,
  output logic [N-1:0]    s_axis_tready,
  output logic            m_axis_tvalid,
  output logic [DW-1:0]   m_axis_tdata,
  output logic            m_axis_tlast,
  input  logic            m_axis_tready,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_id,
  output logic [15:0]     pkt_cnt
);
  typedef enum logic {ARB, LOCK} state_t;
  state_t state;
  logic [IW-1:0] ptr, pick;
  logic any, lock, done;
  // Scanning downward lets the index nearest ptr (searching upward with wrap) win.
  always_comb begin
    any = 1'b0;
    pick = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (s_axis_tvalid[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        pick = IW'((int'(ptr) + k) % N);
      end
    end
  end
  assign lock          = (state == LOCK);
  assign grant_valid   = lock;
  assign m_axis_tvalid = lock & s_axis_tvalid[grant_id];
  assign m_axis_tlast  = lock & s_axis_tlast[grant_id];
  assign m_axis_tdata  = lock ? s_axis_tdata[int'(grant_id)*DW +: DW] : '0;
  assign s_axis_tready = lock ? (N'(m_axis_tready) << grant_id) : '0;
  assign done          = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state    <= ARB;
      ptr      <= '0;
      grant_id <= '0;
      pkt_cnt  <= '0;
    end else if (!lock) begin
      if (any) begin
        grant_id <= pick;
        state    <= LOCK;
      end
    end else if (done) begin
      state   <= ARB;
      ptr     <= (grant_id == IW'(N - 1)) ? '0 : grant_id + IW'(1);
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: scoreboard bench for axis_rr_arbiter (N=4, DW=8)
module tb_axis_rr_arbiter;
  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       last;
  } beat_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  s_valid = '0;
  logic [31:0] s_data = '0;
  logic [3:0]  s_last = '0;
  logic [3:0]  s_ready;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_ready = 1'b1;
  logic        g_valid;
  logic [1:0]  g_id;
  logic [15:0] pkt_cnt;
  logic [3:0]  hold = '0;
  beat_t       rq[4][$];
  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  axis_rr_arbiter #(.N(4), .DW(8)) dut (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tlast(s_last),
    .s_axis_tready(s_ready), .m_axis_tvalid(m_valid), .m_axis_tdata(m_data),
    .m_axis_tlast(m_last), .m_axis_tready(m_ready),
    .grant_valid(g_valid), .grant_id(g_id), .pkt_cnt(pkt_cnt)
  );
  always #5 clk = ~clk;
  // Requester models plus scoreboard monitor: sample mid-cycle, update drive just after the edge.
  initial begin
    logic [3:0] fire;
    beat_t e;
    forever begin
      @(negedge clk);
      fire = s_valid & s_ready;
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat: unexpected beat id=%0d data=%h last=%b, none required", g_id, m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          if ({g_id, m_data, m_last} !== {e.id, e.data, e.last}) begin
            errors++;
            $display("FAIL beat: got id=%0d data=%h last=%b, want id=%0d data=%h last=%b",
                     g_id, m_data, m_last, e.id, e.data, e.last);
          end
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (fire[i] && rst_n && rq[i].size() > 0) void'(rq[i].pop_front());
        s_valid[i] = (rq[i].size() > 0) && !hold[i];
        s_data[i*8 +: 8] = (rq[i].size() > 0) ? rq[i][0].data : 8'h00;
        s_last[i] = (rq[i].size() > 0) ? rq[i][0].last : 1'b0;
      end
    end
  end
  task automatic push(input int i, input logic [7:0] d, input logic l);
    beat_t b;
    b.id = 2'(i);
    b.data = d;
    b.last = l;
    rq[i].push_back(b);
  endtask
  task automatic expect_beat(input int i, input logic [7:0] d, input logic l);
    beat_t b;
    b.id = 2'(i);
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask
  task automatic enter_reset();
    rst_n = 1'b0;
    hold = '0;
    m_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) rq[i].delete();
  endtask
  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drain(input string name);
    int n;
    n = 0;
    while (n < 100 && !(exp_q.size() == 0 && rq[0].size() == 0 && rq[1].size() == 0 &&
                        rq[2].size() == 0 && rq[3].size() == 0)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s drain: %0d beats still expected after 100 cycles, want 0", name, exp_q.size());
    end
  endtask
  task automatic test_reset();
    enter_reset();
    push(0, 8'hAA, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({g_valid, g_id, m_valid, m_data, m_last, s_ready, pkt_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gv=%b id=%0d mv=%b md=%h ml=%b sr=%b cnt=%0d, want all 0",
               g_valid, g_id, m_valid, m_data, m_last, s_ready, pkt_cnt);
    end
    enter_reset();
    release_reset();
    @(negedge clk);
    checks++;
    if ({g_valid, s_ready, pkt_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_idle: gv=%b sr=%b cnt=%0d, want 0", g_valid, s_ready, pkt_cnt);
    end
  endtask
  task automatic test_single_req();
    enter_reset();
    for (int k = 0; k < 4; k++) begin
      push(2, 8'(8'h10 + k), k == 3);
      expect_beat(2, 8'(8'h10 + k), k == 3);
    end
    release_reset();
    step();
    checks++;
    if (g_valid !== 1'b1 || g_id !== 2'd2) begin
      errors++;
      $display("FAIL single_grant: gv=%b id=%0d, want gv=1 id=2", g_valid, g_id);
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'(8'h10 + k)) begin
        errors++;
        $display("FAIL single_beat%0d: mv=%b data=%h, want mv=1 data=%h", k, m_valid, m_data, 8'(8'h10 + k));
      end
    end
    step();
    checks++;
    if (g_valid !== 1'b0 || pkt_cnt !== 16'd1) begin
      errors++;
      $display("FAIL single_end: gv=%b cnt=%0d, want gv=0 cnt=1", g_valid, pkt_cnt);
    end
    drain("single");
  endtask
  task automatic test_round_robin();
    enter_reset();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++)
        for (int b = 0; b < 2; b++) begin
          push(i, 8'(i * 16 + p * 2 + b), b == 1);
          expect_beat(i, 8'(i * 16 + p * 2 + b), b == 1);
        end
    release_reset();
    repeat (24) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pkt_cnt !== 16'd8 || g_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_count: cnt=%0d gv=%b, want cnt=8 gv=0", pkt_cnt, g_valid);
    end
    drain("rr");
  endtask
  task automatic test_backpressure();
    logic [3:0] pat;
    logic [7:0] want;
    pat = 4'b1001;
    enter_reset();
    for (int k = 0; k < 3; k++) begin
      push(1, 8'(8'h50 + k), k == 2);
      expect_beat(1, 8'(8'h50 + k), k == 2);
    end
    push(3, 8'h70, 1'b1);
    expect_beat(3, 8'h70, 1'b1);
    release_reset();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 m_ready = pat[3 - k];
      @(negedge clk);
      want = (k == 0) ? 8'h50 : 8'h51;
      checks++;
      if (g_id !== 2'd1 || m_data !== want || s_ready !== {2'b00, m_ready, 1'b0}) begin
        errors++;
        $display("FAIL bp_cycle%0d: id=%0d data=%h sr=%b, want id=1 data=%h sr=%b",
                 k, g_id, m_data, s_ready, want, {2'b00, m_ready, 1'b0});
      end
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    drain("bp");
  endtask
  task automatic test_owner_stall();
    enter_reset();
    for (int k = 0; k < 3; k++) begin
      push(3, 8'(8'h30 + k), k == 2);
      expect_beat(3, 8'(8'h30 + k), k == 2);
    end
    expect_beat(0, 8'h0F, 1'b1);
    release_reset();
    step();
    hold[3] = 1'b1;
    push(0, 8'h0F, 1'b1);
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (g_valid !== 1'b1 || g_id !== 2'd3 || m_valid !== 1'b0 || s_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d: gv=%b id=%0d mv=%b sr=%b, want gv=1 id=3 mv=0 sr[0]=0",
                 k, g_valid, g_id, m_valid, s_ready);
      end
    end
    hold[3] = 1'b0;
    drain("stall");
    checks++;
    if (pkt_cnt !== 16'd2) begin
      errors++;
      $display("FAIL stall_count: cnt=%0d, want 2", pkt_cnt);
    end
  endtask
  task automatic test_reset_mid_packet();
    int n;
    enter_reset();
    push(2, 8'h20, 1'b1);
    expect_beat(2, 8'h20, 1'b1);
    release_reset();
    step();
    for (int k = 0; k < 4; k++) begin
      push(1, 8'(8'h40 + k), k == 3);
      expect_beat(1, 8'(8'h40 + k), k == 3);
    end
    n = 0;
    while (exp_q.size() > 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (n >= 50 || {g_valid, g_id, m_valid, m_data, m_last, s_ready, pkt_cnt} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: gv=%b id=%0d mv=%b md=%h sr=%b cnt=%0d wait=%0d, want all 0",
               g_valid, g_id, m_valid, m_data, s_ready, pkt_cnt, n);
    end
    enter_reset();
    push(3, 8'h33, 1'b1);
    push(1, 8'h1A, 1'b1);
    expect_beat(1, 8'h1A, 1'b1);
    expect_beat(3, 8'h33, 1'b1);
    release_reset();
    step();
    checks++;
    if (g_valid !== 1'b1 || g_id !== 2'd1 || pkt_cnt !== 16'd0) begin
      errors++;
      $display("FAIL abort_regrant: gv=%b id=%0d cnt=%0d, want gv=1 id=1 cnt=0", g_valid, g_id, pkt_cnt);
    end
    drain("abort");
  endtask
  task automatic test_single_beat();
    logic [1:0] ids [4];
    ids = '{2'd0, 2'd2, 2'd0, 2'd2};
    enter_reset();
    for (int p = 0; p < 2; p++) begin
      push(0, 8'(8'hC0 + p), 1'b1);
      push(2, 8'(8'hE0 + p), 1'b1);
      expect_beat(0, 8'(8'hC0 + p), 1'b1);
      expect_beat(2, 8'(8'hE0 + p), 1'b1);
    end
    release_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (g_valid !== ~k[0] || (!k[0] && g_id !== ids[k/2])) begin
        errors++;
        $display("FAIL sbeat_cycle%0d: gv=%b id=%0d, want gv=%b id=%0d", k, g_valid, g_id, ~k[0], ids[k/2]);
      end
    end
    drain("sbeat");
  endtask
  initial begin
    test_reset();
    test_single_req();
    test_round_robin();
    test_backpressure();
    test_owner_stall();
    test_reset_mid_packet();
    test_single_beat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
